// File: rtl/pulse_width_meter.sv
// pulse_width_meter
//   Samples a single-bit pulse line and measures the width of each high pulse.
//   The width is the number of clk edges at which the line was sampled high.
//   One result is reported per pulse, one cycle after the fall is sampled,
//   together with three classification flags.
//
// Ports
//   clk        in   1   clock
//   rst        in   1   synchronous reset, active-high
//   sig        in   1   pulse line, synchronous to clk
//   busy       out  1   high while a pulse is being measured
//   valid      out  1   one-cycle strobe: width/flags carry a new result
//   width      out  CW  measured high-cycle count, saturated at MAX_LEN
//   match      out  1   width within EXP_LEN +/- TOL and not too_long
//   too_short  out  1   width < MIN_LEN
//   too_long   out  1   pulse stayed high past MAX_LEN cycles
module pulse_width_meter #(
    parameter int MAX_LEN = 15,
    parameter int MIN_LEN = 2,
    parameter int EXP_LEN = 6,
    parameter int TOL     = 1,
    parameter int CW      = $clog2(MAX_LEN + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          sig,
    output logic          busy,
    output logic          valid,
    output logic [CW-1:0] width,
    output logic          match,
    output logic          too_short,
    output logic          too_long
);

    if (MAX_LEN < 1) begin : g_bad_max_len
        $error("pulse_width_meter: MAX_LEN must be >= 1");
    end
    if (MIN_LEN < 1 || MIN_LEN > MAX_LEN) begin : g_bad_min_len
        $error("pulse_width_meter: MIN_LEN must be in 1..MAX_LEN");
    end
    if (EXP_LEN - TOL < 1) begin : g_bad_window_lo
        $error("pulse_width_meter: EXP_LEN-TOL must be >= 1");
    end
    if (EXP_LEN + TOL > MAX_LEN) begin : g_bad_window_hi
        $error("pulse_width_meter: EXP_LEN+TOL must be <= MAX_LEN");
    end

    localparam logic [CW-1:0] MAX_C = CW'(MAX_LEN);
    localparam logic [CW-1:0] MIN_C = CW'(MIN_LEN);
    localparam logic [CW-1:0] LO_C  = CW'(EXP_LEN - TOL);
    localparam logic [CW-1:0] HI_C  = CW'(EXP_LEN + TOL);

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic            sig_q, sig_d;
    logic            rise;

    logic            busy_q, busy_d;
    logic            valid_q, valid_d;
    logic [CW-1:0]   width_q, width_d;
    logic            match_q, match_d;
    logic            too_short_q, too_short_d;
    logic            too_long_q, too_long_d;

    // sig_q resets to 1 so a line already high at reset release never
    // produces a rise; the remainder of such a pulse is ignored.
    assign rise = sig & ~sig_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ovf_d       = ovf_q;
        sig_d       = sig;
        valid_d     = 1'b0;
        width_d     = width_q;
        match_d     = match_q;
        too_short_d = too_short_q;
        too_long_d  = too_long_q;

        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = MEASURE;
                    cnt_d   = CW'(1);
                    ovf_d   = 1'b0;
                end
            end
            MEASURE: begin
                if (sig) begin
                    // Saturate at MAX_LEN; one more high sample marks overflow.
                    if (cnt_q < MAX_C) begin
                        cnt_d = cnt_q + CW'(1);
                    end else begin
                        ovf_d = 1'b1;
                    end
                end else begin
                    state_d     = IDLE;
                    valid_d     = 1'b1;
                    width_d     = cnt_q;
                    too_long_d  = ovf_q;
                    too_short_d = (cnt_q < MIN_C) && !ovf_q;
                    match_d     = !ovf_q && (cnt_q >= LO_C) && (cnt_q <= HI_C);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == MEASURE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            ovf_q       <= 1'b0;
            sig_q       <= 1'b1;
            busy_q      <= 1'b0;
            valid_q     <= 1'b0;
            width_q     <= '0;
            match_q     <= 1'b0;
            too_short_q <= 1'b0;
            too_long_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ovf_q       <= ovf_d;
            sig_q       <= sig_d;
            busy_q      <= busy_d;
            valid_q     <= valid_d;
            width_q     <= width_d;
            match_q     <= match_d;
            too_short_q <= too_short_d;
            too_long_q  <= too_long_d;
        end
    end

    assign busy      = busy_q;
    assign valid     = valid_q;
    assign width     = width_q;
    assign match     = match_q;
    assign too_short = too_short_q;
    assign too_long  = too_long_q;

endmodule

// File: tb/tb_pulse_width_meter.sv
// tb_pulse_width_meter
//   Directed bench for pulse_width_meter with MAX_LEN=15, MIN_LEN=2,
//   EXP_LEN=6, TOL=1 (match window 5..7).
module tb_pulse_width_meter;

    localparam int CW = 4;

    logic          clk;
    logic          rst;
    logic          sig;
    logic          busy;
    logic          valid;
    logic [CW-1:0] width;
    logic          match;
    logic          too_short;
    logic          too_long;

    int tests_run;
    int failed;

    int vcount;
    int busy_cnt;
    int ok6;
    logic [CW-1:0] last_w;
    logic last_m, last_s, last_l;

    pulse_width_meter #(
        .MAX_LEN(15),
        .MIN_LEN(2),
        .EXP_LEN(6),
        .TOL(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .sig(sig),
        .busy(busy),
        .valid(valid),
        .width(width),
        .match(match),
        .too_short(too_short),
        .too_long(too_long)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive sig for one clock, then sample outputs 1 time unit after the edge.
    task automatic step(input logic s);
        sig = s;
        @(posedge clk);
        #1;
        if (valid === 1'b1) begin
            vcount++;
            last_w = width;
            last_m = match;
            last_s = too_short;
            last_l = too_long;
            if (width === 4'd6 && match === 1'b1) ok6++;
        end
        if (busy === 1'b1) busy_cnt++;
    endtask

    task automatic clear_counts();
        vcount   = 0;
        busy_cnt = 0;
        ok6      = 0;
    endtask

    task automatic pulse(input int hi, input int lo);
        for (int i = 0; i < hi; i++) step(1'b1);
        for (int i = 0; i < lo; i++) step(1'b0);
    endtask

    typedef struct {
        int len;
        int w;
        logic m;
        logic s;
        logic l;
    } vec_t;

    vec_t table_v[7];

    initial begin
        tests_run = 0;
        failed    = 0;
        clear_counts();
        last_w = '0; last_m = 1'b0; last_s = 1'b0; last_l = 1'b0;
        rst = 1'b1;
        sig = 1'b0;

        // Reset state
        step(1'b0);
        step(1'b0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_valid",     32'(valid),     32'd0);
        chk("rst_width",     32'(width),     32'd0);
        chk("rst_match",     32'(match),     32'd0);
        chk("rst_too_short", 32'(too_short), 32'd0);
        chk("rst_too_long",  32'(too_long),  32'd0);
        #1 rst = 1'b0;
        step(1'b0);
        step(1'b0);

        // 1. Nominal 6-cycle pulse
        clear_counts();
        pulse(6, 0);
        chk("t1_busy_cnt_high", 32'(busy_cnt), 32'd6);
        chk("t1_no_valid_high", 32'(vcount),   32'd0);
        step(1'b0);
        chk("t1_valid_latency", 32'(valid), 32'd1);
        chk("t1_busy_after",    32'(busy),  32'd0);
        step(1'b0);
        chk("t1_valid_1cycle",  32'(valid), 32'd0);
        step(1'b0);
        chk("t1_vcount",  32'(vcount), 32'd1);
        chk("t1_width",   32'(last_w), 32'd6);
        chk("t1_match",   32'(last_m), 32'd1);
        chk("t1_short",   32'(last_s), 32'd0);
        chk("t1_long",    32'(last_l), 32'd0);
        chk("t1_hold_w",  32'(width),  32'd6);

        // 2. Single-cycle pulse
        clear_counts();
        pulse(1, 3);
        chk("t2_vcount", 32'(vcount), 32'd1);
        chk("t2_width",  32'(last_w), 32'd1);
        chk("t2_short",  32'(last_s), 32'd1);
        chk("t2_match",  32'(last_m), 32'd0);
        chk("t2_long",   32'(last_l), 32'd0);

        // 3. Overlong pulse: no report while high, single saturated report
        clear_counts();
        pulse(20, 0);
        chk("t3_no_valid_high", 32'(vcount), 32'd0);
        chk("t3_busy_high",     32'(busy),   32'd1);
        chk("t3_hold_w_high",   32'(width),  32'd1);
        pulse(0, 4);
        chk("t3_vcount", 32'(vcount), 32'd1);
        chk("t3_width",  32'(last_w), 32'd15);
        chk("t3_long",   32'(last_l), 32'd1);
        chk("t3_match",  32'(last_m), 32'd0);
        chk("t3_short",  32'(last_s), 32'd0);

        // Boundary table: len -> width, match, too_short, too_long
        table_v[0] = '{2,  2,  1'b0, 1'b0, 1'b0};
        table_v[1] = '{4,  4,  1'b0, 1'b0, 1'b0};
        table_v[2] = '{5,  5,  1'b1, 1'b0, 1'b0};
        table_v[3] = '{7,  7,  1'b1, 1'b0, 1'b0};
        table_v[4] = '{8,  8,  1'b0, 1'b0, 1'b0};
        table_v[5] = '{15, 15, 1'b0, 1'b0, 1'b0};
        table_v[6] = '{16, 15, 1'b0, 1'b0, 1'b1};
        for (int k = 0; k < 7; k++) begin
            clear_counts();
            pulse(table_v[k].len, 2);
            chk($sformatf("tab%0d_vcount", table_v[k].len), 32'(vcount), 32'd1);
            chk($sformatf("tab%0d_width",  table_v[k].len), 32'(last_w), 32'(table_v[k].w));
            chk($sformatf("tab%0d_match",  table_v[k].len), 32'(last_m), 32'(table_v[k].m));
            chk($sformatf("tab%0d_short",  table_v[k].len), 32'(last_s), 32'(table_v[k].s));
            chk($sformatf("tab%0d_long",   table_v[k].len), 32'(last_l), 32'(table_v[k].l));
        end

        // 4. Back-to-back pulses separated by one low cycle
        clear_counts();
        pulse(3, 1);
        chk("t4_valid1",   32'(valid), 32'd1);
        chk("t4_width1",   32'(width), 32'd3);
        step(1'b1);
        chk("t4_busy2_rise", 32'(busy),  32'd1);
        chk("t4_valid1_end", 32'(valid), 32'd0);
        pulse(3, 1);
        chk("t4_valid2",   32'(valid), 32'd1);
        chk("t4_width2",   32'(width), 32'd4);
        pulse(0, 2);
        chk("t4_vcount",   32'(vcount), 32'd2);

        // 5. Reset during the third cycle of a 6-cycle pulse
        clear_counts();
        step(1'b1);
        step(1'b1);
        rst = 1'b1;
        step(1'b1);
        rst = 1'b0;
        chk("t5_busy_rst",  32'(busy),  32'd0);
        chk("t5_width_rst", 32'(width), 32'd0);
        clear_counts();
        pulse(3, 3);
        chk("t5_no_valid", 32'(vcount),   32'd0);
        chk("t5_no_busy",  32'(busy_cnt), 32'd0);
        clear_counts();
        pulse(5, 2);
        chk("t5_vcount", 32'(vcount), 32'd1);
        chk("t5_width",  32'(last_w), 32'd5);
        chk("t5_match",  32'(last_m), 32'd1);

        // 6. Stream of 6-cycle generator pulses with varying gaps
        clear_counts();
        pulse(6, 1);
        pulse(6, 3);
        pulse(6, 2);
        pulse(6, 1);
        pulse(6, 1);
        pulse(0, 3);
        chk("t6_vcount", 32'(vcount), 32'd5);
        chk("t6_ok6",    32'(ok6),    32'd5);

        $display("[TB] %0d tests run, %0d failed", tests_run, failed);
        $finish;
    end

endmodule
